transpose_memory_ctrl: RTL

//  Sequencer for the banked NUM_PE x NUM_PE transpose memory. Fills one matrix row-per-cycle

---
 rtl/transpose_memory_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/transpose_memory_ctrl.sv
// transpose_memory_ctrl
//   Fill/drain sequencer for a banked NUM_PE x NUM_PE transpose memory.
//   Rows are written one per cycle with a diagonal skew (bank i, addr r holds
//   A[r][(i-r) mod NUM_PE]) and drained one column per cycle under
//   ready/valid backpressure.
//   Optional feature macro: TRANSPOSE_BYPASS_EN. When defined, ctrl=1 sampled on
//   the first accepted row selects pass-through (rows drained unmodified).
//   Without it, ctrl is ignored and every matrix is transposed.
module transpose_memory_ctrl #(
    parameter  int NUM_MG     = 8,
    parameter  int NUM_PE     = NUM_MG,
    localparam int ADDR_WIDTH = $clog2(NUM_PE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ctrl,
    input  logic                         in_val,
    output logic                         in_rdy,
    output logic                         out_val,
    input  logic                         out_rdy,
    output logic                         write_e,
    output logic [ADDR_WIDTH-1:0]        write_addr,
    output logic [ADDR_WIDTH-1:0]        wr_rot,
    output logic [NUM_MG*ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH-1:0]        rd_rot,
    output logic                         busy
);

    // Counters wrap by truncation, so the geometry must be a power of two.
    generate
        if (NUM_PE < 2 || (NUM_PE & (NUM_PE - 1)) != 0) begin : g_bad_num_pe
            $error("transpose_memory_ctrl: NUM_PE must be a power of two >= 2");
        end
        if (NUM_MG != NUM_PE) begin : g_bad_num_mg
            $error("transpose_memory_ctrl: NUM_MG must equal NUM_PE");
        end
    endgenerate

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_PE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [ADDR_WIDTH-1:0] col_cnt_q, col_cnt_d;
    logic [ADDR_WIDTH-1:0] rd_rot_q, rd_rot_d;
    logic                  out_val_q, out_val_d;
    logic                  issued_all_q, issued_all_d;
    logic                  mode_q, mode_d;

    logic                  accept;
    logic                  issue;
    logic                  out_hs;
    logic                  ctrl_eff;
    logic [ADDR_WIDTH-1:0] rd_col;

`ifdef TRANSPOSE_BYPASS_EN
    assign ctrl_eff = ctrl;
`else
    logic unused_ctrl;
    assign unused_ctrl = ctrl;
    assign ctrl_eff    = 1'b0;
`endif

    assign in_rdy  = (state_q != DRAIN);
    assign accept  = in_val & in_rdy;
    assign out_hs  = out_val_q & out_rdy;
    // A new column read may be issued whenever the output slot is free or
    // being emptied this cycle.
    assign issue   = (state_q == DRAIN) & ~issued_all_q & (~out_val_q | out_rdy);

    assign write_e    = accept;
    assign write_addr = row_cnt_q;
    assign wr_rot     = row_cnt_q;
    assign out_val    = out_val_q;
    assign rd_rot     = rd_rot_q;
    assign busy       = (state_q != IDLE);

    // Column whose address the banks see: the column being issued, or the
    // last issued one (rd_rot_q) while stalled, so read_data stays put.
    assign rd_col = issue ? col_cnt_q : rd_rot_q;

    // Per-bank read address: skewed column fetch, or flat row fetch in bypass.
    always_comb begin
        read_addr = '0;
        if (state_q == DRAIN) begin
            for (int unsigned i = 0; i < NUM_MG; i++) begin
                read_addr[i*ADDR_WIDTH +: ADDR_WIDTH] =
                    mode_q ? rd_col : (ADDR_WIDTH'(i) - rd_col);
            end
        end
    end

    // Next-state logic for the fill/drain sequencer.
    always_comb begin
        state_d      = state_q;
        row_cnt_d    = row_cnt_q;
        col_cnt_d    = col_cnt_q;
        rd_rot_d     = rd_rot_q;
        out_val_d    = out_val_q;
        issued_all_d = issued_all_q;
        mode_d       = mode_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    mode_d    = ctrl_eff;
                    row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
                    state_d   = (row_cnt_q == LAST) ? DRAIN : FILL;
                end
            end

            FILL: begin
                if (accept) begin
                    row_cnt_d = row_cnt_q + ADDR_WIDTH'(1);
                    if (row_cnt_q == LAST) begin
                        state_d = DRAIN;
                    end
                end
            end

            DRAIN: begin
                if (issue) begin
                    col_cnt_d = col_cnt_q + ADDR_WIDTH'(1);
                    rd_rot_d  = col_cnt_q;
                    out_val_d = 1'b1;
                    if (col_cnt_q == LAST) begin
                        issued_all_d = 1'b1;
                    end
                end else if (out_hs) begin
                    out_val_d = 1'b0;
                end

                // Last column handed off: matrix done, return to a clean idle.
                if (out_hs && issued_all_q) begin
                    state_d      = IDLE;
                    out_val_d    = 1'b0;
                    issued_all_d = 1'b0;
                    col_cnt_d    = '0;
                    rd_rot_d     = '0;
                    mode_d       = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            row_cnt_q    <= '0;
            col_cnt_q    <= '0;
            rd_rot_q     <= '0;
            out_val_q    <= 1'b0;
            issued_all_q <= 1'b0;
            mode_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_cnt_q    <= row_cnt_d;
            col_cnt_q    <= col_cnt_d;
            rd_rot_q     <= rd_rot_d;
            out_val_q    <= out_val_d;
            issued_all_q <= issued_all_d;
            mode_q       <= mode_d;
        end
    end

endmodule
